mul_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared 4x4 shift-add multiplier datapath. The block accepts multiply requests from two independent clients over valid/ready handshakes and picks one under the selected arbitration policy. It then loads the datapath, runs the four shift-add iterations, and returns the 8-bit product to the owning client with a one-cycle response pulse. It sits between the client blocks and the single multiplier instance, so the multiplier never needs duplicating.

---
 rtl/mul_pkg.sv | 20 ++
 rtl/mul_dp.sv | 58 +++++
 rtl/mul_arb.sv | 135 +++++++++++++
 tb/tb_mul_arb.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the mul_arb multiplier sequencer
//
// Purpose: state encoding, operand/product widths and the last iteration index
//          used by mul_arb and mul_dp.
// Ports:   none (package).
package mul_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  // Step counter value on which the final shift-add iteration is taken.
  localparam logic [1:0] ITER_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_dp.sv
// rtl/mul_dp.sv - 4x4 shift-add multiplier datapath registers
//
// Purpose: holds the multiplicand (ra) and the combined partial-product /
//          multiplier register (ry); performs one shift-add iteration per step.
// Ports:
//   clk   in  1       clock
//   rst   in  1       synchronous active-low reset
//   load  in  1       load ra=a, ry={0,b}
//   step  in  1       perform one iteration
//   a     in  OP_W    multiplicand
//   b     in  OP_W    multiplier
//   ry    out PROD_W  product register
module mul_dp
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] ry
);

  logic [OP_W-1:0]   ra_q, ra_d;
  logic [PROD_W-1:0] ry_q, ry_d;
  logic [OP_W:0]     w_add;

  always_comb begin
    ra_d  = ra_q;
    ry_d  = ry_q;
    // Upper half plus multiplicand; the carry becomes the new MSB after the shift.
    w_add = {1'b0, ry_q[PROD_W-1:OP_W]} + {1'b0, ra_q};
    if (load) begin
      ra_d = a;
      ry_d = {{(PROD_W-OP_W){1'b0}}, b};
    end else if (step) begin
      if (ry_q[0]) begin
        ry_d = {w_add, ry_q[OP_W-1:1]};
      end else begin
        ry_d = {1'b0, ry_q[PROD_W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ra_q <= '0;
      ry_q <= '0;
    end else begin
      ra_q <= ra_d;
      ry_q <= ry_d;
    end
  end

  assign ry = ry_q;

endmodule

// File: rtl/mul_arb.sv
// rtl/mul_arb.sv - two-requester arbiter and sequencer for the shared shift-add multiplier
//
// Purpose: grants one of two requesters, runs four shift-add iterations on
//          mul_dp and returns the product with a one-cycle response pulse.
//          Define MUL_ARB_RR_EN for round-robin arbitration; otherwise
//          requester 0 has fixed priority.
// Ports:
//   clk         in  1  clock
//   rst         in  1  synchronous active-low reset
//   req_valid   in  2  per-requester request valid
//   req_a0/b0   in  4  requester 0 operands
//   req_a1/b1   in  4  requester 1 operands
//   req_ready   out 2  one-hot grant (IDLE only)
//   resp_valid  out 2  one-hot response pulse to the owner
//   resp_y      out 8  product, meaningful while resp_valid != 0
//   busy        out 1  high in every state except IDLE
module mul_arb
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [OP_W-1:0]   req_a0,
  input  logic [OP_W-1:0]   req_b0,
  input  logic [OP_W-1:0]   req_a1,
  input  logic [OP_W-1:0]   req_b1,
  output logic [1:0]        req_ready,
  output logic [1:0]        resp_valid,
  output logic [PROD_W-1:0] resp_y,
  output logic              busy
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic [1:0] grant;
  logic       hs;
  logic       load;
  logic       step;
  logic [OP_W-1:0] dp_a, dp_b;

`ifdef MUL_ARB_RR_EN
  // ptr_q set means requester 1 is favoured on the next simultaneous request.
  logic ptr_q, ptr_d;
`endif

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
`ifdef MUL_ARB_RR_EN
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
`else
      2'b11:   grant = 2'b01;
`endif
      default: grant = 2'b00;
    endcase
  end

  // Ready is held low while reset is asserted so no handshake can occur then.
  assign req_ready = (state_q == IDLE && rst) ? grant : 2'b00;
  assign hs        = |(req_valid & req_ready);

  assign dp_a = req_ready[1] ? req_a1 : req_a0;
  assign dp_b = req_ready[1] ? req_b1 : req_b0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = CALC;
          cnt_d   = 2'd0;
          owner_d = req_ready[1];
          load    = 1'b1;
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == ITER_LAST) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MUL_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = req_ready[0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      owner_q <= 1'b0;
`ifdef MUL_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
`ifdef MUL_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  mul_dp u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (dp_a),
    .b    (dp_b),
    .ry   (resp_y)
  );

  assign resp_valid = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mul_arb.sv
// tb/tb_mul_arb.sv - self-checking testbench for mul_arb with a transaction-level model
module tb_mul_arb;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0] req_ready;
  logic [1:0] resp_valid;
  logic [7:0] resp_y;
  logic       busy;

  int n_checks;
  int n_errors;

  // Model: cycles until idle, owner, expected product, last served requester.
  int         m_left;
  logic       m_owner;
  logic [7:0] m_prod;
  logic       m_last;
  logic       m_zero;

  logic [1:0] obs_ready, obs_rv;
  logic [7:0] obs_y;
  logic       obs_busy;

  mul_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_grant(input logic [1:0] v);
    if (v == 2'b01) return 2'b01;
    if (v == 2'b10) return 2'b10;
    if (v == 2'b11) begin
`ifdef MUL_ARB_RR_EN
      return m_last ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    return 2'b00;
  endfunction

  // One clock cycle: drive, sample, compare with model, advance model.
  task automatic tick(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] b0,
                      input logic [3:0] a1, input logic [3:0] b1, input logic r);
    logic [1:0] exp_ready;
    @(negedge clk);
    rst = r; req_valid = v;
    req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
    #1;
    obs_ready = req_ready; obs_rv = resp_valid; obs_y = resp_y; obs_busy = busy;
    if (r) begin
      exp_ready = (m_left == 0) ? model_grant(v) : 2'b00;
      chk("ready", {30'd0, obs_ready}, {30'd0, exp_ready});
      chk("busy", {31'd0, obs_busy}, {31'd0, m_left != 0});
      chk("resp_valid", {30'd0, obs_rv}, (m_left == 1) ? (32'd1 << m_owner) : 32'd0);
      if (m_left == 1) chk("resp_y", {24'd0, obs_y}, {24'd0, m_prod});
      else if (m_zero) chk("resp_y_zero", {24'd0, obs_y}, 32'd0);
      if (m_left > 0) m_left--;
      if (exp_ready != 2'b00) begin
        m_owner = exp_ready[1];
        m_prod  = m_owner ? ({4'd0, a1} * {4'd0, b1}) : ({4'd0, a0} * {4'd0, b0});
        m_left  = 5;
        m_zero  = 1'b0;
        m_last  = m_owner;
      end
    end else begin
      m_left = 0; m_owner = 1'b0; m_last = 1'b1; m_zero = 1'b1;
    end
  endtask

  task automatic do_reset();
    tick(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    tick(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  // Lone request from requester 0; explicit product check in T+5.
  task automatic single0(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_y);
    tick(2'b01, a, b, 4'd0, 4'd0, 1'b1);
    chk("single_ready", {30'd0, obs_ready}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick(2'b00, ~a, ~b, 4'd0, 4'd0, 1'b1);
      chk("single_busy", {31'd0, obs_busy}, 32'd1);
    end
    chk("single_rv", {30'd0, obs_rv}, 32'd1);
    chk("single_y", {24'd0, obs_y}, {24'd0, exp_y});
    tick(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    chk("single_idle", {31'd0, obs_busy}, 32'd0);
  endtask

  initial begin
    int grants[$];
    int hit;
    logic [1:0] pend;
    logic [3:0] ops [4];

    n_checks = 0; n_errors = 0;
    m_left = 0; m_owner = 0; m_prod = 0; m_last = 1; m_zero = 1;
    rst = 1'b0; req_valid = 0; req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;

    do_reset();
    tick(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    chk("rst_ready", {30'd0, obs_ready}, 32'd0);
    chk("rst_rv", {30'd0, obs_rv}, 32'd0);
    chk("rst_y", {24'd0, obs_y}, 32'd0);
    chk("rst_busy", {31'd0, obs_busy}, 32'd0);

    single0(4'd3, 4'd5, 8'd15);
    single0(4'd15, 4'd15, 8'hE1);
    single0(4'd0, 4'd9, 8'd0);
    single0(4'd9, 4'd0, 8'd0);
    single0(4'd1, 4'd15, 8'h0F);

    // Both requesters continuously valid.
    do_reset();
    for (int c = 0; c < 24; c++) begin
      tick(2'b11, 4'd2, 4'd7, 4'd4, 4'd4, 1'b1);
      if (obs_ready != 2'b00) grants.push_back(obs_ready[1] ? 1 : 0);
    end
    chk("both_ngrants", grants.size(), 32'd4);
    for (int k = 0; k < 4 && k < grants.size(); k++) begin
`ifdef MUL_ARB_RR_EN
      chk("both_order", grants[k], k % 2);
`else
      chk("both_order", grants[k], 32'd0);
`endif
    end
    for (int c = 0; c < 6; c++) tick(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

    // Requester 1 changes operands during CALC.
    tick(2'b10, 4'd0, 4'd0, 4'd3, 4'd6, 1'b1);
    for (int i = 1; i <= 5; i++) tick(2'b00, 4'd0, 4'd0, 4'd15, 4'd15, 1'b1);
    chk("sample_rv", {30'd0, obs_rv}, 32'd2);
    chk("sample_y", {24'd0, obs_y}, 32'd18);
    tick(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

    // Reset in the third CALC cycle aborts without a response.
    tick(2'b01, 4'd7, 4'd7, 4'd0, 4'd0, 1'b1);
    tick(2'b00, 4'd7, 4'd7, 4'd0, 4'd0, 1'b1);
    tick(2'b00, 4'd7, 4'd7, 4'd0, 4'd0, 1'b1);
    tick(2'b00, 4'd7, 4'd7, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
      chk("abort_busy", {31'd0, obs_busy}, 32'd0);
      chk("abort_rv", {30'd0, obs_rv}, 32'd0);
      chk("abort_y", {24'd0, obs_y}, 32'd0);
    end
    single0(4'd6, 4'd5, 8'd30);

    // Request arriving during busy is granted in the first IDLE cycle.
    tick(2'b01, 4'd2, 4'd2, 4'd0, 4'd0, 1'b1);
    tick(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    hit = -1;
    for (int c = 2; c < 10; c++) begin
      tick(2'b10, 4'd0, 4'd0, 4'd5, 4'd3, 1'b1);
      if (obs_ready[1] && hit < 0) hit = c;
      if (obs_ready[1]) break;
    end
    chk("late_grant_cycle", hit, 32'd6);
    for (int i = 0; i < 6; i++) tick(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

    // Randomized traffic; pending requests hold operands until granted.
    pend = 2'b00;
    for (int k = 0; k < 4; k++) ops[k] = 4'd0;
    for (int c = 0; c < 1500; c++) begin
      logic r;
      r = ($urandom_range(0, 199) != 0);
      for (int q = 0; q < 2; q++) begin
        if (!pend[q]) begin
          ops[2*q]   = 4'($urandom);
          ops[2*q+1] = 4'($urandom);
          if ($urandom_range(0, 2) == 0) pend[q] = 1'b1;
        end
      end
      tick(pend, ops[0], ops[1], ops[2], ops[3], r);
      if (r) pend = pend & ~obs_ready;
      else pend = 2'b00;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
